// File: rtl/pong_ball.sv
// rtl/pong_ball.sv - ball position, wall/paddle bounce and miss detection engine
// One move per axis per tick; serve delay and score pulses sequenced by a small FSM.
module pong_ball #(
  parameter int CLKS_PER_MOVE     = 250_000,
  parameter int ACTIVE_ROWS       = 480,
  parameter int ACTIVE_COLS       = 640,
  parameter int BALL_SIZE         = 8,
  parameter int PADDLE_WIDTH      = 16,
  parameter int PADDLE_HEIGHT     = 64,
  parameter int SERVE_DELAY_MOVES = 120
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(ACTIVE_ROWS)-1:0] left_pos,
  input  logic [$clog2(ACTIVE_ROWS)-1:0] right_pos,
  input  logic [$clog2(ACTIVE_ROWS)-1:0] row,
  input  logic [$clog2(ACTIVE_COLS)-1:0] col,
  output logic                           ball_present,
  output logic [$clog2(ACTIVE_COLS)-1:0] ball_x,
  output logic [$clog2(ACTIVE_ROWS)-1:0] ball_y,
  output logic                           score_left,
  output logic                           score_right,
  output logic                           in_play
);

  localparam int RW  = $clog2(ACTIVE_ROWS);
  localparam int CW  = $clog2(ACTIVE_COLS);
  localparam int MCW = (CLKS_PER_MOVE > 0) ? $clog2(CLKS_PER_MOVE + 1) : 1;
  localparam int SCW = (SERVE_DELAY_MOVES > 1) ? $clog2(SERVE_DELAY_MOVES) : 1;
  localparam int WW  = RW + 2;
  localparam int XW  = CW + 1;

  localparam logic [CW-1:0]  CX         = CW'((ACTIVE_COLS - BALL_SIZE) / 2);
  localparam logic [RW-1:0]  CY         = RW'((ACTIVE_ROWS - BALL_SIZE) / 2);
  localparam logic [CW-1:0]  X_MAX      = CW'(ACTIVE_COLS - BALL_SIZE);
  localparam logic [RW-1:0]  Y_MAX      = RW'(ACTIVE_ROWS - BALL_SIZE);
  localparam logic [CW-1:0]  L_FACE     = CW'(3 * PADDLE_WIDTH / 2);
  localparam logic [CW-1:0]  R_FACE     = CW'(ACTIVE_COLS - 1 - 3 * PADDLE_WIDTH / 2 - BALL_SIZE);
  localparam logic [MCW-1:0] MOVE_LAST  = MCW'(CLKS_PER_MOVE);
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_DELAY_MOVES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE_WAIT,
    S_PLAY,
    S_SCORED
  } state_t;

  state_t         state_q;
  logic [MCW-1:0] move_cnt_q;
  logic [SCW-1:0] serve_cnt_q;
  logic [CW-1:0]  ball_x_q, ball_x_d;
  logic [RW-1:0]  ball_y_q, ball_y_d;
  logic           dx_pos_q, dx_pos_d;
  logic           dy_pos_q, dy_pos_d;
  logic           score_left_q, score_right_q;

  logic           tick;
  logic           exit_left, exit_right;
  logic           ov_left, ov_right;

  // Row arithmetic is widened so paddle bottoms near the last row never wrap.
  logic [WW-1:0]  y_top_w, y_bot_w;
  logic [WW-1:0]  lp_top_w, lp_bot_w, rp_top_w, rp_bot_w;
  logic [WW-1:0]  row_w;
  logic [XW-1:0]  x_left_w, x_right_w, col_w;

  assign tick = (move_cnt_q == MOVE_LAST);

  assign y_top_w  = WW'(ball_y_q);
  assign y_bot_w  = WW'(ball_y_q) + WW'(BALL_SIZE);
  assign lp_top_w = WW'(left_pos);
  assign lp_bot_w = WW'(left_pos) + WW'(PADDLE_HEIGHT);
  assign rp_top_w = WW'(right_pos);
  assign rp_bot_w = WW'(right_pos) + WW'(PADDLE_HEIGHT);

  assign ov_left  = (y_bot_w > lp_top_w) && (y_top_w < lp_bot_w);
  assign ov_right = (y_bot_w > rp_top_w) && (y_top_w < rp_bot_w);

  assign row_w     = WW'(row);
  assign col_w     = XW'(col);
  assign x_left_w  = XW'(ball_x_q);
  assign x_right_w = XW'(ball_x_q) + XW'(BALL_SIZE);

  assign ball_present = (row_w >= y_top_w) && (row_w < y_bot_w) &&
                        (col_w >= x_left_w) && (col_w < x_right_w);

  always_comb begin
    ball_y_d = ball_y_q;
    dy_pos_d = dy_pos_q;
    if (!dy_pos_q && (ball_y_q == '0)) begin
      dy_pos_d = 1'b1;
      ball_y_d = RW'(1);
    end else if (dy_pos_q && (ball_y_q == Y_MAX)) begin
      dy_pos_d = 1'b0;
      ball_y_d = ball_y_q - RW'(1);
    end else if (dy_pos_q) begin
      ball_y_d = ball_y_q + RW'(1);
    end else begin
      ball_y_d = ball_y_q - RW'(1);
    end
  end

  // Paddles only deflect at their exact face column; a ball already past it keeps going.
  always_comb begin
    ball_x_d   = ball_x_q;
    dx_pos_d   = dx_pos_q;
    exit_left  = 1'b0;
    exit_right = 1'b0;
    if (!dx_pos_q && (ball_x_q == L_FACE) && ov_left) begin
      dx_pos_d = 1'b1;
      ball_x_d = L_FACE + CW'(1);
    end else if (dx_pos_q && (ball_x_q == R_FACE) && ov_right) begin
      dx_pos_d = 1'b0;
      ball_x_d = R_FACE - CW'(1);
    end else if (!dx_pos_q && (ball_x_q == '0)) begin
      exit_left = 1'b1;
    end else if (dx_pos_q && (ball_x_q == X_MAX)) begin
      exit_right = 1'b1;
    end else if (dx_pos_q) begin
      ball_x_d = ball_x_q + CW'(1);
    end else begin
      ball_x_d = ball_x_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      move_cnt_q    <= '0;
      serve_cnt_q   <= '0;
      ball_x_q      <= CX;
      ball_y_q      <= CY;
      dx_pos_q      <= 1'b1;
      dy_pos_q      <= 1'b1;
      score_left_q  <= 1'b0;
      score_right_q <= 1'b0;
    end else begin
      score_left_q  <= 1'b0;
      score_right_q <= 1'b0;
      move_cnt_q    <= tick ? '0 : move_cnt_q + MCW'(1);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_SERVE_WAIT;
            serve_cnt_q <= '0;
          end
        end
        S_SERVE_WAIT: begin
          if (tick) begin
            if (serve_cnt_q == SERVE_LAST) begin
              state_q <= S_PLAY;
            end else begin
              serve_cnt_q <= serve_cnt_q + SCW'(1);
            end
          end
        end
        S_PLAY: begin
          if (tick) begin
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_pos_q <= dx_pos_d;
            dy_pos_q <= dy_pos_d;
            // Exit direction doubles as the next serve direction: toward the conceding side.
            if (exit_left) begin
              score_right_q <= 1'b1;
              dx_pos_q      <= 1'b0;
              state_q       <= S_SCORED;
            end else if (exit_right) begin
              score_left_q <= 1'b1;
              dx_pos_q     <= 1'b1;
              state_q      <= S_SCORED;
            end
          end
        end
        S_SCORED: begin
          ball_x_q    <= CX;
          ball_y_q    <= CY;
          dy_pos_q    <= 1'b1;
          serve_cnt_q <= '0;
          state_q     <= S_SERVE_WAIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign in_play     = (state_q == S_PLAY);

endmodule

// File: tb/tb_pong_ball.sv
// tb/tb_pong_ball.sv - randomized self-checking bench for pong_ball against a tick-level game model
module tb_pong_ball;

  localparam int CPM    = 1;
  localparam int SD     = 2;
  localparam int ROWS   = 480;
  localparam int COLS   = 640;
  localparam int BALL   = 8;
  localparam int PW     = 16;
  localparam int PH     = 64;
  localparam int CX     = (COLS - BALL) / 2;
  localparam int CY     = (ROWS - BALL) / 2;
  localparam int L_FACE = 3 * PW / 2;
  localparam int R_EDGE = COLS - 1 - 3 * PW / 2;

  localparam int HIT_EDGE  = 0;
  localparam int HIT_RAND  = 1;
  localparam int MISS_EDGE = 2;
  localparam int MISS_RAND = 3;
  localparam int ANY_POS   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] left_pos = '0, right_pos = '0, row = '0;
  logic [9:0] col = '0;
  logic       ball_present, score_left, score_right, in_play;
  logic [9:0] ball_x;
  logic [8:0] ball_y;

  always #5 clk = ~clk;

  pong_ball #(
    .CLKS_PER_MOVE(CPM),
    .ACTIVE_ROWS(ROWS),
    .ACTIVE_COLS(COLS),
    .BALL_SIZE(BALL),
    .PADDLE_WIDTH(PW),
    .PADDLE_HEIGHT(PH),
    .SERVE_DELAY_MOVES(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .left_pos(left_pos),
    .right_pos(right_pos),
    .row(row),
    .col(col),
    .ball_present(ball_present),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .score_left(score_left),
    .score_right(score_right),
    .in_play(in_play)
  );

  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_SCORED} phase_t;
  phase_t      ms;
  int          mx, my, mdx, mdy, mclk, mticks, ev_lhit, ev_rhit;
  bit          msl, msr;
  logic [22:0] exp_v, care;
  int          n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic model_reset();
    ms = M_IDLE; mx = CX; my = CY; mdx = 1; mdy = 1;
    mclk = 0; mticks = 0; msl = 0; msr = 0;
  endtask

  function automatic bit overlap(int y, int p);
    return (y + BALL > p) && (y < p + PH);
  endfunction

  // Game rules at tick granularity: walls reflect, paddle faces reflect, leaving the field scores.
  task automatic model_clock();
    bit tick;
    int nx, ny;
    tick = (mclk == CPM);
    mclk = tick ? 0 : mclk + 1;
    msl = 0; msr = 0;
    case (ms)
      M_IDLE: if (start) begin ms = M_SERVE; mticks = 0; end
      M_SERVE: if (tick) begin
        mticks++;
        if (mticks == SD) ms = M_PLAY;
      end
      M_PLAY: if (tick) begin
        ny = my + mdy;
        if (ny < 0 || ny > ROWS - BALL) begin mdy = -mdy; ny = my + mdy; end
        nx = mx + mdx;
        if ((mdx < 0 && mx == L_FACE && overlap(my, int'(left_pos))) ||
            (mdx > 0 && mx + BALL == R_EDGE && overlap(my, int'(right_pos)))) begin
          if (mdx < 0) ev_lhit++; else ev_rhit++;
          mdx = -mdx;
          nx = mx + mdx;
        end else if (nx < 0) begin
          msr = 1; ms = M_SCORED; nx = mx;
        end else if (nx + BALL > COLS) begin
          msl = 1; ms = M_SCORED; nx = mx;
        end
        mx = nx; my = ny;
      end
      M_SCORED: begin mx = CX; my = CY; mdy = 1; ms = M_SERVE; mticks = 0; end
    endcase
  endtask

  function automatic int pick(int mode, int y);
    int r, lo, lim;
    case (mode)
      HIT_EDGE:  r = y + BALL - 1;
      HIT_RAND: begin
        lo = (y - PH + 1 < 0) ? 0 : y - PH + 1;
        r = int'($urandom_range(y + BALL - 1, lo));
      end
      MISS_EDGE: r = y + BALL;
      MISS_RAND: begin
        lim = (y - PH > 20) ? 20 : y - PH;
        if (y >= PH && $urandom_range(1, 0) == 1) r = y - PH - int'($urandom_range(lim, 0));
        else r = y + BALL + int'($urandom_range(20, 0));
      end
      default:   r = int'($urandom_range(ROWS - 1, 0));
    endcase
    return r;
  endfunction

  task automatic cycle(input int lmode, input int rmode, input bit st);
    int r, c;
    @(posedge clk);
    model_clock();
    cyc++;
    #1;
    start     = st;
    left_pos  = 9'(pick(lmode, my));
    right_pos = 9'(pick(rmode, my));
    r = my - 4 + int'($urandom_range(15, 0));
    c = mx - 4 + int'($urandom_range(15, 0));
    if (r < 0) r = 0;
    if (r > ROWS - 1) r = ROWS - 1;
    if (c < 0) c = 0;
    if (c > COLS - 1) c = COLS - 1;
    row = 9'(r);
    col = 10'(c);
    exp_v = {10'(mx), 9'(my), (r >= my && r < my + BALL && c >= mx && c < mx + BALL),
             ms == M_PLAY, msl, msr};
    care = (ms == M_SCORED) ? 23'h7 : '1;
    #1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (ball_x !== 10'(CX)) begin n_bad++; $display("FAIL reset_x: got %0d required %0d", ball_x, CX); end
    n_cmp++; if (ball_y !== 9'(CY)) begin n_bad++; $display("FAIL reset_y: got %0d required %0d", ball_y, CY); end
    @(posedge clk); #1;
    n_cmp++; if ({in_play, score_left, score_right} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b required 000", {in_play, score_left, score_right});
    end
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_serve();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle(ANY_POS, ANY_POS, i == 4);
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL serve cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
      done = (ms == M_PLAY);
    end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL serve_timeout: in_play got 0 required 1"); end
  endtask

  task automatic test_right_hit();
    int base = ev_rhit;
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      cycle(ANY_POS, HIT_EDGE, 1'($urandom_range(1, 0)));
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL right_hit cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
      done = (ev_rhit != base);
    end
    n_cmp++;
    if (!done || ball_x !== 10'(R_EDGE - BALL - 1)) begin
      n_bad++; $display("FAIL right_rebound_x: got %0d required %0d", ball_x, R_EDGE - BALL - 1);
    end
  endtask

  task automatic test_left_hit();
    int base = ev_lhit;
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      cycle(HIT_RAND, ANY_POS, 1'($urandom_range(1, 0)));
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL left_hit cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
      done = (ev_lhit != base);
    end
    n_cmp++;
    if (!done || ball_x !== 10'(L_FACE + 1)) begin
      n_bad++; $display("FAIL left_rebound_x: got %0d required %0d", ball_x, L_FACE + 1);
    end
  endtask

  task automatic test_right_miss();
    int  sl_hi = 0, sr_hi = 0;
    bit  scored = 0, done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cycle(ANY_POS, MISS_EDGE, 1'b0);
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL right_miss cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
      sl_hi += int'(score_left === 1'b1);
      sr_hi += int'(score_right === 1'b1);
      if (msl) scored = 1;
      done = scored && (ms == M_PLAY);
    end
    n_cmp++;
    if (!done || sl_hi != 1 || sr_hi != 0) begin
      n_bad++; $display("FAIL score_left_pulse: got left=%0d right=%0d clks required 1 and 0", sl_hi, sr_hi);
    end
  endtask

  task automatic test_left_miss();
    int  sl_hi = 0, sr_hi = 0;
    bit  scored = 0, done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      cycle(MISS_RAND, HIT_RAND, 1'b0);
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL left_miss cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
      sl_hi += int'(score_left === 1'b1);
      sr_hi += int'(score_right === 1'b1);
      if (msr) scored = 1;
      done = scored && (ms == M_PLAY);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(ANY_POS, ANY_POS, 1'b1);
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL reserve_left cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
    end
    n_cmp++;
    if (!done || sr_hi != 1 || sl_hi != 0) begin
      n_bad++; $display("FAIL score_right_pulse: got right=%0d left=%0d clks required 1 and 0", sr_hi, sl_hi);
    end
  endtask

  task automatic test_reset_midplay();
    int n = int'($urandom_range(60, 5));
    for (int i = 0; i < n; i++) begin
      cycle(ANY_POS, ANY_POS, 1'b1);
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL midplay cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
    end
    #1;
    rst   = 1'b1;
    start = 1'b0;
    row   = 9'(CY);
    col   = 10'(CX);
    #1;
    n_cmp++;
    if ({ball_x, ball_y, in_play, score_left, score_right, ball_present} !== {10'(CX), 9'(CY), 4'b0001}) begin
      n_bad++; $display("FAIL async_reset: got x=%0d y=%0d play=%b sl=%b sr=%b bp=%b required %0d %0d 0 0 0 1",
                        ball_x, ball_y, in_play, score_left, score_right, ball_present, CX, CY);
    end
    model_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({in_play, score_left, score_right} !== 3'b000) begin
      n_bad++; $display("FAIL reset_hold: got %b required 000", {in_play, score_left, score_right});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(ANY_POS, ANY_POS, 1'b0);
      n_cmp++;
      if (({ball_x, ball_y, ball_present, in_play, score_left, score_right} & care) !== (exp_v & care)) begin
        n_bad++; $display("FAIL idle_after_reset cyc %0d: got %h required %h", cyc,
                          {ball_x, ball_y, ball_present, in_play, score_left, score_right} & care, exp_v & care);
      end
    end
  endtask

  initial begin
    ev_lhit = 0;
    ev_rhit = 0;
    model_reset();
    test_reset();
    test_serve();
    test_right_hit();
    test_left_hit();
    test_right_miss();
    test_left_miss();
    test_reset_midplay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
